// File: rtl/sha256_pkg.sv
// Shared types and defaults for the single-block SHA-256 sequencer.
package sha256_pkg;

    localparam int DEF_MAX_BYTES   = 55;
    localparam int DEF_N_WORDS     = 16;
    localparam int DEF_N_ROUNDS    = 64;
    localparam int DEF_PAD_TIMEOUT = 64;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_PAD,
        ST_STREAM,
        ST_ROUND,
        ST_DONE,
        ST_ERR,
        ST_FLUSH
    } state_t;

    localparam logic [1:0] ERR_NONE = 2'b00;
    localparam logic [1:0] ERR_LEN  = 2'b01;
    localparam logic [1:0] ERR_OVF  = 2'b10;
    localparam logic [1:0] ERR_TMO  = 2'b11;

endpackage

// File: rtl/sha256_byte_fwd.sv
// Registered UART-to-padder byte forwarder with message length check.
// One cycle latency; a byte past MAX_BYTES is dropped and flagged via len_err.
module sha256_byte_fwd
    import sha256_pkg::*;
#(
    parameter int MAX_BYTES = DEF_MAX_BYTES
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       en,
    input  logic       byte_rdy_in,
    input  logic [7:0] data_in,
    output logic       pad_byte_rdy,
    output logic [7:0] pad_data,
    output logic       len_err
);

    logic [6:0] byte_cnt;
    logic       fwd;

    assign len_err = en && byte_rdy_in && (byte_cnt == 7'(MAX_BYTES));
    assign fwd     = en && byte_rdy_in && !len_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            pad_byte_rdy <= 1'b0;
            pad_data     <= 8'h00;
            byte_cnt     <= 7'd0;
        end else begin
            pad_byte_rdy <= fwd;
            if (fwd) begin
                pad_data <= data_in;
                byte_cnt <= byte_cnt + 7'd1;
            end else if (clr) begin
                byte_cnt <= 7'd0;
            end
        end
    end

endmodule

// File: rtl/sha256_block_ctrl.sv
// Single-block SHA-256 sequencer: byte load, padding supervision, word stream, 64 rounds, digest handoff.
// Words are qualified combinationally by padding_done; the digest is held until digest_ack.
module sha256_block_ctrl
    import sha256_pkg::*;
#(
    parameter int MAX_BYTES   = DEF_MAX_BYTES,
    parameter int N_WORDS     = DEF_N_WORDS,
    parameter int N_ROUNDS    = DEF_N_ROUNDS,
    parameter int PAD_TIMEOUT = DEF_PAD_TIMEOUT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       byte_rdy_in,
    input  logic       byte_stop_in,
    input  logic [7:0] data_in,
    output logic       pad_byte_rdy,
    output logic       pad_byte_stop,
    output logic [7:0] pad_data,
    output logic       pad_rst_n,
    input  logic       padding_done,
    input  logic       overflow_err,
    input  logic       flag_0_15,
    output logic       w_valid,
    output logic [3:0] w_index,
    output logic       init_h,
    output logic       round_en,
    output logic [5:0] round_idx,
    output logic       digest_valid,
    input  logic       digest_ack,
    output logic       busy,
    output logic       err,
    output logic [1:0] err_code,
    input  logic       err_clr
);

    state_t     state;
    logic [4:0] wcnt;
    logic [6:0] rcnt;
    logic [6:0] tcnt;
    logic       fwd_en;
    logic       len_err;
    logic       last_word;

    assign fwd_en = (state == ST_IDLE) || ((state == ST_LOAD) && !overflow_err);

    sha256_byte_fwd #(
        .MAX_BYTES (MAX_BYTES)
    ) u_fwd (
        .clk          (clk),
        .rst          (rst),
        .clr          (state == ST_FLUSH),
        .en           (fwd_en),
        .byte_rdy_in  (byte_rdy_in),
        .data_in      (data_in),
        .pad_byte_rdy (pad_byte_rdy),
        .pad_data     (pad_data),
        .len_err      (len_err)
    );

    // Word 0 rides on the PAD cycle that first sees padding_done.
    assign w_valid = padding_done && !overflow_err &&
                     ((state == ST_PAD) || ((state == ST_STREAM) && (wcnt < 5'(N_WORDS))));
    assign w_index      = wcnt[3:0];
    assign last_word    = w_valid && (wcnt == 5'(N_WORDS - 1));
    assign init_h       = (state == ST_IDLE) && byte_rdy_in;
    assign round_en     = (state == ST_ROUND);
    assign round_idx    = rcnt[5:0];
    assign digest_valid = (state == ST_DONE);
    assign busy         = (state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            wcnt          <= 5'd0;
            rcnt          <= 7'd0;
            tcnt          <= 7'd0;
            err           <= 1'b0;
            err_code      <= ERR_NONE;
            pad_byte_stop <= 1'b0;
            pad_rst_n     <= 1'b0;
        end else begin
            pad_rst_n <= 1'b1;
            case (state)
                ST_IDLE: begin
                    if (byte_rdy_in) state <= ST_LOAD;
                end
                ST_LOAD: begin
                    if (overflow_err) begin
                        state    <= ST_ERR;
                        err      <= 1'b1;
                        err_code <= ERR_OVF;
                    end else if (len_err) begin
                        state    <= ST_ERR;
                        err      <= 1'b1;
                        err_code <= ERR_LEN;
                    end else if (byte_stop_in && !byte_rdy_in) begin
                        state         <= ST_PAD;
                        pad_byte_stop <= 1'b1;
                        tcnt          <= 7'd0;
                    end
                end
                ST_PAD: begin
                    if (overflow_err) begin
                        state         <= ST_ERR;
                        err           <= 1'b1;
                        err_code      <= ERR_OVF;
                        pad_byte_stop <= 1'b0;
                    end else if (padding_done) begin
                        state <= ST_STREAM;
                        wcnt  <= 5'd1;
                    end else if (tcnt == 7'(PAD_TIMEOUT - 1)) begin
                        state         <= ST_ERR;
                        err           <= 1'b1;
                        err_code      <= ERR_TMO;
                        pad_byte_stop <= 1'b0;
                    end else begin
                        tcnt <= tcnt + 7'd1;
                    end
                end
                ST_STREAM: begin
                    // flag_0_15 is legal only alongside the final word.
                    if (overflow_err || (flag_0_15 && !last_word)) begin
                        state         <= ST_ERR;
                        err           <= 1'b1;
                        err_code      <= ERR_OVF;
                        pad_byte_stop <= 1'b0;
                    end else if (last_word) begin
                        state         <= ST_ROUND;
                        rcnt          <= 7'd0;
                        pad_byte_stop <= 1'b0;
                    end else if (w_valid) begin
                        wcnt <= wcnt + 5'd1;
                    end
                end
                ST_ROUND: begin
                    if (rcnt == 7'(N_ROUNDS - 1)) state <= ST_DONE;
                    else                          rcnt  <= rcnt + 7'd1;
                end
                ST_DONE: begin
                    if (digest_ack) begin
                        state     <= ST_FLUSH;
                        pad_rst_n <= 1'b0;
                    end
                end
                ST_ERR: begin
                    if (err_clr) begin
                        state     <= ST_FLUSH;
                        pad_rst_n <= 1'b0;
                        err       <= 1'b0;
                        err_code  <= ERR_NONE;
                    end
                end
                ST_FLUSH: begin
                    state <= ST_IDLE;
                    wcnt  <= 5'd0;
                    rcnt  <= 7'd0;
                    tcnt  <= 7'd0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sha256_block_ctrl.sv
// Bench for sha256_block_ctrl: scenarios are planned up front as per-cycle stimulus and
// expected-output timelines, then replayed and compared every cycle on the falling edge.
module tb_sha256_block_ctrl;

    localparam int NSLOT = 1024;
    localparam int P_IDLE = 0, P_LOAD = 1, P_PAD = 2, P_STREAM = 3,
                   P_ROUND = 4, P_DONE = 5, P_ERR = 6, P_FLUSH = 7;

    typedef struct packed {
        logic       rst, rdy, stop;
        logic [7:0] dat;
        logic       pd, ovf, flag, ack, clr;
    } stim_t;

    typedef struct packed {
        logic       chk, chk_widx, chk_bcnt;
        logic       pbr, pbs;
        logic [7:0] pdat;
        logic       prn, wv;
        logic [3:0] widx;
        logic       ih, re;
        logic [5:0] ridx;
        logic       dv, busy, err;
        logic [1:0] ec;
    } exp_t;

    stim_t s [NSLOT];
    exp_t  e [NSLOT];
    int    t;
    int    cur;
    bit    running;
    int    errors;
    int    checks;

    logic       clk = 1'b1;
    logic       rst, byte_rdy_in, byte_stop_in;
    logic [7:0] data_in;
    logic       padding_done, overflow_err, flag_0_15, digest_ack, err_clr;
    logic       pad_byte_rdy, pad_byte_stop, pad_rst_n;
    logic [7:0] pad_data;
    logic       w_valid, init_h, round_en, digest_valid, busy, err;
    logic [3:0] w_index;
    logic [5:0] round_idx;
    logic [1:0] err_code;

    always #5 clk = ~clk;

    sha256_block_ctrl u_dut (
        .clk           (clk),
        .rst           (rst),
        .byte_rdy_in   (byte_rdy_in),
        .byte_stop_in  (byte_stop_in),
        .data_in       (data_in),
        .pad_byte_rdy  (pad_byte_rdy),
        .pad_byte_stop (pad_byte_stop),
        .pad_data      (pad_data),
        .pad_rst_n     (pad_rst_n),
        .padding_done  (padding_done),
        .overflow_err  (overflow_err),
        .flag_0_15     (flag_0_15),
        .w_valid       (w_valid),
        .w_index       (w_index),
        .init_h        (init_h),
        .round_en      (round_en),
        .round_idx     (round_idx),
        .digest_valid  (digest_valid),
        .digest_ack    (digest_ack),
        .busy          (busy),
        .err           (err),
        .err_code      (err_code),
        .err_clr       (err_clr)
    );

    // ---------------- timeline planning ----------------
    task automatic ph(input int c, input int p);
        e[c].busy = (p != P_IDLE);
        e[c].pbs  = (p == P_PAD) || (p == P_STREAM);
        e[c].dv   = (p == P_DONE);
        e[c].err  = (p == P_ERR);
        if (p == P_FLUSH) e[c].prn = 1'b0;
    endtask

    task automatic bytes_in(input int n, input logic [7:0] base, input bit same_stop);
        for (int k = 0; k < n; k++) begin
            s[t].rdy  = 1'b1;
            s[t].dat  = 8'(base + k);
            s[t].stop = same_stop && (k == n - 1);
            ph(t, (k == 0) ? P_IDLE : P_LOAD);
            e[t].ih     = (k == 0);
            e[t+1].pbr  = 1'b1;
            e[t+1].pdat = 8'(base + k);
            t++;
        end
    endtask

    task automatic stop_in();
        s[t].stop = 1'b1;
        ph(t, P_LOAD);
        t++;
    endtask

    task automatic words(input int pad_wait, input int stall_at, input int stall_len, input int n_words);
        for (int i = 0; i < pad_wait; i++) begin
            ph(t, P_PAD);
            t++;
        end
        for (int w = 0; w < n_words; w++) begin
            if (w == stall_at) begin
                for (int i = 0; i < stall_len; i++) begin
                    ph(t, P_STREAM);
                    e[t].chk_widx = 1'b1;
                    e[t].widx     = 4'(w);
                    t++;
                end
            end
            s[t].pd = 1'b1;
            ph(t, (w == 0) ? P_PAD : P_STREAM);
            e[t].wv       = 1'b1;
            e[t].chk_widx = 1'b1;
            e[t].widx     = 4'(w);
            t++;
        end
    endtask

    task automatic rounds(input int rst_at);
        for (int r = 0; r < 64; r++) begin
            ph(t, P_ROUND);
            e[t].re   = 1'b1;
            e[t].ridx = 6'(r);
            if (r == rst_at) begin
                s[t].rst = 1'b1;
                t++;
                return;
            end
            t++;
        end
    endtask

    task automatic finish_digest(input int ack_delay);
        for (int i = 0; i < ack_delay; i++) begin
            ph(t, P_DONE);
            t++;
        end
        s[t].ack = 1'b1;
        ph(t, P_DONE);
        t++;
        ph(t, P_FLUSH);
        t++;
    endtask

    task automatic err_hold(input logic [1:0] code, input int hold);
        for (int i = 0; i < hold; i++) begin
            ph(t, P_ERR);
            e[t].ec = code;
            t++;
        end
        s[t].clr = 1'b1;
        ph(t, P_ERR);
        e[t].ec = code;
        t++;
        ph(t, P_FLUSH);
        t++;
    endtask

    task automatic plan_all();
        for (int c = 0; c < NSLOT; c++) begin
            s[c] = '0;
            e[c] = '0;
            e[c].chk = 1'b1;
            e[c].prn = 1'b1;
        end
        t = 0;
        for (int i = 0; i < 3; i++) begin s[t].rst = 1'b1; t++; end
        e[0].chk = 1'b0;
        t += 2;
        s[t].stop = 1'b1; t++;                       // stop level alone in IDLE is ignored
        t += 2;
        bytes_in(3, 8'h61, 1'b0); stop_in(); words(2, -1, 0, 16); rounds(-1); finish_digest(3); t += 2;
        bytes_in(55, 8'h20, 1'b0); stop_in(); words(0, -1, 0, 16); rounds(-1); finish_digest(0); t += 2;
        bytes_in(55, 8'h30, 1'b0);
        s[t].rdy = 1'b1; s[t].dat = 8'h99; ph(t, P_LOAD); t++;
        e[t].chk_bcnt = 1'b1;
        err_hold(2'b01, 3); t += 2;
        bytes_in(3, 8'h61, 1'b0); stop_in();
        for (int i = 0; i < 64; i++) begin ph(t, P_PAD); t++; end
        err_hold(2'b11, 2); t += 2;
        bytes_in(3, 8'h61, 1'b0); stop_in(); words(1, 6, 3, 16); rounds(-1); finish_digest(1); t += 2;
        bytes_in(1, 8'h61, 1'b1); stop_in(); words(0, -1, 0, 16); rounds(20); t += 2;
        bytes_in(3, 8'h61, 1'b0); stop_in(); words(0, -1, 0, 16); rounds(-1); finish_digest(0); t += 2;
        bytes_in(2, 8'h41, 1'b0);
        s[t].ovf = 1'b1; ph(t, P_LOAD); t++;
        err_hold(2'b10, 1); t += 2;
        bytes_in(1, 8'h55, 1'b0); stop_in(); words(0, -1, 0, 4);
        s[t].flag = 1'b1; ph(t, P_STREAM); e[t].chk_widx = 1'b1; e[t].widx = 4'd4; t++;
        err_hold(2'b10, 1); t += 2;
        // The padder reset output stays low for the cycle after any reset edge.
        for (int c = 0; c < t; c++) if (s[c].rst) e[c+1].prn = 1'b0;
    endtask

    // ---------------- replay and compare ----------------
    task automatic apply(input int c);
        rst          = s[c].rst;
        byte_rdy_in  = s[c].rdy;
        byte_stop_in = s[c].stop;
        data_in      = s[c].dat;
        padding_done = s[c].pd;
        overflow_err = s[c].ovf;
        flag_0_15    = s[c].flag;
        digest_ack   = s[c].ack;
        err_clr      = s[c].clr;
    endtask

    task automatic cmp(input string nm, input int c, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", nm, c, act, expv);
        end
    endtask

    int         n_re, n_wv, n_ih, n_dv, n_err, n_cap;
    logic [1:0] ec_seq [4];
    logic [7:0] cap [3];
    logic       prev_dv, prev_err;

    initial begin
        n_re = 0; n_wv = 0; n_ih = 0; n_dv = 0; n_err = 0; n_cap = 0;
        prev_dv = 1'b0; prev_err = 1'b0;
        for (int i = 0; i < 4; i++) ec_seq[i] = 2'b00;
        for (int i = 0; i < 3; i++) cap[i] = 8'h00;
        forever begin
            @(negedge clk);
            if (running && e[cur].chk) begin
                cmp("pad_byte_rdy",  cur, 32'(pad_byte_rdy),  32'(e[cur].pbr));
                cmp("pad_byte_stop", cur, 32'(pad_byte_stop), 32'(e[cur].pbs));
                cmp("pad_rst_n",     cur, 32'(pad_rst_n),     32'(e[cur].prn));
                cmp("w_valid",       cur, 32'(w_valid),       32'(e[cur].wv));
                cmp("init_h",        cur, 32'(init_h),        32'(e[cur].ih));
                cmp("round_en",      cur, 32'(round_en),      32'(e[cur].re));
                cmp("digest_valid",  cur, 32'(digest_valid),  32'(e[cur].dv));
                cmp("busy",          cur, 32'(busy),          32'(e[cur].busy));
                cmp("err",           cur, 32'(err),           32'(e[cur].err));
                cmp("err_code",      cur, 32'(err_code),      32'(e[cur].ec));
                if (e[cur].pbr)      cmp("pad_data",  cur, 32'(pad_data),  32'(e[cur].pdat));
                if (e[cur].chk_widx) cmp("w_index",   cur, 32'(w_index),   32'(e[cur].widx));
                if (e[cur].re)       cmp("round_idx", cur, 32'(round_idx), 32'(e[cur].ridx));
                if (e[cur].chk_bcnt) cmp("byte_cnt",  cur, 32'(u_dut.u_fwd.byte_cnt), 32'd55);
                if (round_en === 1'b1) n_re++;
                if (w_valid === 1'b1)  n_wv++;
                if (init_h === 1'b1)   n_ih++;
                if (digest_valid === 1'b1 && prev_dv !== 1'b1) n_dv++;
                if (err === 1'b1 && prev_err !== 1'b1) begin
                    if (n_err < 4) ec_seq[n_err] = err_code;
                    n_err++;
                end
                if (pad_byte_rdy === 1'b1 && n_cap < 3) begin
                    cap[n_cap] = pad_data;
                    n_cap++;
                end
                prev_dv  = digest_valid;
                prev_err = err;
            end
        end
    end

    initial begin
        int         n_slots;
        logic [1:0] ec_ref [4];
        logic [7:0] cap_ref [3];
        errors  = 0;
        checks  = 0;
        running = 1'b0;
        plan_all();
        n_slots = t;
        apply(0);
        cur     = 0;
        running = 1'b1;
        for (int c = 1; c < n_slots; c++) begin
            @(posedge clk);
            #1;
            apply(c);
            cur = c;
        end
        @(posedge clk);
        #1;
        running = 1'b0;

        // Whole-run totals worked out by hand from the scenario list.
        cmp("round_en_cycles",  0, 32'(n_re),  32'd277);
        cmp("w_valid_cycles",   0, 32'(n_wv),  32'd84);
        cmp("init_h_pulses",    0, 32'(n_ih),  32'd9);
        cmp("digests_offered",  0, 32'(n_dv),  32'd4);
        cmp("errors_raised",    0, 32'(n_err), 32'd4);
        ec_ref[0] = 2'b01; ec_ref[1] = 2'b11; ec_ref[2] = 2'b10; ec_ref[3] = 2'b10;
        for (int i = 0; i < 4; i++) cmp("err_code_sequence", i, 32'(ec_seq[i]), 32'(ec_ref[i]));
        cap_ref[0] = 8'h61; cap_ref[1] = 8'h62; cap_ref[2] = 8'h63;
        for (int i = 0; i < 3; i++) cmp("first_bytes_abc", i, 32'(cap[i]), 32'(cap_ref[i]));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
